load_reservation_station: RTL and testbench
===========================================

# load_reservation_station

Single-entry reservation station for load (LW) instructions in the Tomasulo out-of-order core. It sits between the issue stage, the common data bus (CDB), the data cache read port and the reorder-buffer write buffer. It accepts one load, resolves its base and offset operands by snooping the CDB, and computes the effective address. It then reads the data cache and returns the loaded word with its reorder-buffer position.

## Interface
Parameters (from the shared Utility constants):
- OPCODE_LENGTH, 4, opcode width; OPCODE_LW is the load opcode.
- REORDER_BUFFER_SIZE_LOG, 4, ROB index width.
- FUNCTION_UNIT_NUMBER, 16, number of CDB slots.
- FUNCTION_UNIT_NUMBER_LOG, 4, tag width.
- NUMBER_OF_BLOCKS_IN_CACHE, 4, number of cache blocks.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  4  opcode offered for issue.
- pos  in  4  ROB position of the offered instruction.
- qi  in  4  destination tag; ignored.
- vi  in  32  destination value; ignored.
- qj  in  4  base-operand tag; 4'hF = ready in vj, otherwise the producing FU index.
- vj  in  32  base value; used only when qj = 4'hF.
- qk  in  4  offset tag; same rule as qj.
- vk  in  32  offset value (immediate); used only when qk = 4'hF.
- commonDataBus  in  512  slot n is bits [32n+31:32n]; 32'hFFFF_FFFF means the slot is idle this cycle.
- busy  out  1  entry occupied.
- writeBuffer_position  out  4  ROB position of the last completed load.
- writeBuffer_value  out  32  data of the last completed load.
- dCache_readPtr  out  32  effective address presented to the cache.
- dCache_readValue  in  32  cache read data.
- dCache_readSuccess  in  1  cache read completes this cycle.
- dCache_busy  in  4  per-block busy flags.

## Operation
- States:
  - IDLE (busy=0).
  - WAIT (busy=1, operands pending or cache busy).
  - READ (busy=1, address on dCache_readPtr).
- Issue happens in IDLE when op == OPCODE_LW. Non-LW opcodes, and any opcode while busy=1, are ignored.
- On issue, latch pos and both operand tags and values.
- CDB snoop applies to every unresolved operand with tag t, including in the issue cycle itself. If CDB slot t is not 32'hFFFF_FFFF, capture the slot value and mark the operand ready. An operand with tag 4'hF is ready at issue and takes its v input.
- Both operands ready and dCache_busy == 4'b0000:
  - register dCache_readPtr = vj + vk (32-bit add, carry discarded, wraps mod 2^32);
  - enter READ.
- Both operands ready and any dCache_busy bit set: remain in WAIT until all bits are clear.
- In READ, hold dCache_readPtr. On an edge where dCache_readSuccess = 1:
  - latch writeBuffer_value = dCache_readValue;
  - latch writeBuffer_position = stored pos;
  - return to IDLE.
- writeBuffer_* hold their values until the next completion. The consumer samples them on the cycle in which busy falls.
- dCache_readSuccess outside READ is ignored.
- A new issue is accepted in the cycle after completion, not the same cycle.
- Reset (async, reset = 0):
  - state to IDLE;
  - busy, dCache_readPtr, writeBuffer_position, writeBuffer_value all cleared to 0;
  - any in-flight load is discarded.

## Timing
- Issue at edge N with both operands ready (from v or the same-cycle CDB): busy=1 and READ with a valid dCache_readPtr after edge N.
- Operand arrives on the CDB in cycle M: READ with address after edge M, which is one cycle after the producer broadcasts.
- Completion: success sampled at edge K gives writeBuffer_* valid and busy=0 after edge K.
- Minimum issue-to-result latency is 2 edges (issue, then success on the next edge).
- Two operands may resolve in the same cycle from different CDB slots.
- Both tags equal: both operands take the same slot.

## Test plan
- Reset low, then high: busy=0, dCache_readPtr=0, writeBuffer_position=0, writeBuffer_value=0.
- Issue LW with pos=0, qj=0, vj=x, qk=4'hF, vk=7 and slot 0 idle. Next cycle slot 0 = 5 → busy=1, dCache_readPtr=12. Then readSuccess=1 with readValue=99 → writeBuffer_value=99, writeBuffer_position=0, busy=0.
- Issue LW with pos=3, qj=qk=4'hF, vj=0xFFFF_FFFF, vk=2 → dCache_readPtr=1 (wrap) in the cycle after issue.
- Operands ready but dCache_busy=4'b0010 for 3 cycles → stays in WAIT. Bits clear → READ with address next edge.
- While busy, offer a second LW with pos=5 → ignored. Completion reports the first load's pos.
- Assert reset mid-READ → busy=0 immediately, and a later readSuccess does not update writeBuffer_*.

Source files
------------

// File: rtl/load_reservation_station.sv
// Single-entry load reservation station: captures one LW, resolves its base and
// offset operands from the CDB, forms the effective address, reads the data
// cache and hands the loaded word plus its ROB position to the write buffer.
module load_reservation_station #(
  parameter int unsigned OPCODE_LENGTH             = 4,
  parameter logic [OPCODE_LENGTH-1:0] OPCODE_LW    = OPCODE_LENGTH'(1),
  parameter int unsigned REORDER_BUFFER_SIZE_LOG   = 4,
  parameter int unsigned FUNCTION_UNIT_NUMBER      = 16,
  parameter int unsigned FUNCTION_UNIT_NUMBER_LOG  = 4,
  parameter int unsigned NUMBER_OF_BLOCKS_IN_CACHE = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [OPCODE_LENGTH-1:0]                     op,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0]           pos,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]          qi,
  input  logic [31:0]                                  vi,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]          qj,
  input  logic [31:0]                                  vj,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]          qk,
  input  logic [31:0]                                  vk,
  input  logic [FUNCTION_UNIT_NUMBER*32-1:0]           commonDataBus,
  output logic                                         busy,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0]           writeBuffer_position,
  output logic [31:0]                                  writeBuffer_value,
  output logic [31:0]                                  dCache_readPtr,
  input  logic [31:0]                                  dCache_readValue,
  input  logic                                         dCache_readSuccess,
  input  logic [NUMBER_OF_BLOCKS_IN_CACHE-1:0]         dCache_busy
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = FUNCTION_UNIT_NUMBER_LOG;
  localparam int unsigned ROB_W   = REORDER_BUFFER_SIZE_LOG;
  localparam logic [TAG_W-1:0]  TAG_READY = '1;
  localparam logic [DATA_W-1:0] SLOT_IDLE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ROB_W-1:0]    pos_q, pos_d;
  logic [TAG_W-1:0]    qj_q, qj_d, qk_q, qk_d;
  logic [DATA_W-1:0]   vj_q, vj_d, vk_q, vk_d;
  logic                j_rdy_q, j_rdy_d, k_rdy_q, k_rdy_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [ROB_W-1:0]    wb_pos_q, wb_pos_d;
  logic [DATA_W-1:0]   wb_val_q, wb_val_d;

  // Operand views after this cycle's CDB snoop
  logic [TAG_W-1:0]    j_tag, k_tag;
  logic [DATA_W-1:0]   j_val, k_val;
  logic                j_rdy, k_rdy;

  // Destination fields are carried on the issue bus but have no use here
  logic                unused_inputs;
  assign unused_inputs = ^{qi, vi};

  // CDB unpacked into one word per functional-unit slot
  logic [DATA_W-1:0]   cdb_slot [FUNCTION_UNIT_NUMBER];
  for (genvar n = 0; n < FUNCTION_UNIT_NUMBER; n++) begin : g_cdb
    assign cdb_slot[n] = commonDataBus[n*DATA_W +: DATA_W];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      qj_q     <= '0;
      qk_q     <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      j_rdy_q  <= 1'b0;
      k_rdy_q  <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wb_pos_q <= '0;
      wb_val_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      j_rdy_q  <= j_rdy_d;
      k_rdy_q  <= k_rdy_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wb_pos_q <= wb_pos_d;
      wb_val_q <= wb_val_d;
    end
  end

  // Operand resolution, next state and next register values
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    j_rdy_d  = j_rdy_q;
    k_rdy_d  = k_rdy_q;
    addr_d   = addr_q;
    wb_pos_d = wb_pos_q;
    wb_val_d = wb_val_q;

    // In IDLE the candidate operands come straight from the issue port so the
    // snoop also covers the issue cycle; otherwise from the stored entry.
    j_tag = qj_q;
    j_val = vj_q;
    j_rdy = j_rdy_q;
    k_tag = qk_q;
    k_val = vk_q;
    k_rdy = k_rdy_q;
    if (state_q == IDLE) begin
      j_tag = qj;
      j_val = vj;
      j_rdy = (qj == TAG_READY);
      k_tag = qk;
      k_val = vk;
      k_rdy = (qk == TAG_READY);
    end
    if (!j_rdy && (cdb_slot[j_tag] != SLOT_IDLE)) begin
      j_rdy = 1'b1;
      j_val = cdb_slot[j_tag];
    end
    if (!k_rdy && (cdb_slot[k_tag] != SLOT_IDLE)) begin
      k_rdy = 1'b1;
      k_val = cdb_slot[k_tag];
    end

    case (state_q)
      IDLE: begin
        if (op == OPCODE_LW) begin
          pos_d   = pos;
          qj_d    = qj;
          qk_d    = qk;
          vj_d    = j_val;
          vk_d    = k_val;
          j_rdy_d = j_rdy;
          k_rdy_d = k_rdy;
          if (j_rdy && k_rdy && (dCache_busy == '0)) begin
            addr_d  = j_val + k_val;
            state_d = READ;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        vj_d    = j_val;
        vk_d    = k_val;
        j_rdy_d = j_rdy;
        k_rdy_d = k_rdy;
        if (j_rdy && k_rdy && (dCache_busy == '0)) begin
          addr_d  = j_val + k_val;
          state_d = READ;
        end
      end
      READ: begin
        if (dCache_readSuccess) begin
          wb_val_d = dCache_readValue;
          wb_pos_d = pos_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy                 = busy_q;
  assign dCache_readPtr       = addr_q;
  assign writeBuffer_position = wb_pos_q;
  assign writeBuffer_value    = wb_val_q;

endmodule

// File: tb/tb_load_reservation_station.sv
// Bench for load_reservation_station: scripted cycle table, reset corner
// sequence, then randomized traffic against a transaction-level model.
module tb_load_reservation_station;

  localparam logic [3:0]  LW   = 4'h1;
  localparam logic [3:0]  RDY  = 4'hF;
  localparam logic [31:0] IDLE_SLOT = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   op, pos, qi, qj, qk;
  logic [31:0]  vi, vj, vk;
  logic [511:0] cdb;
  logic         busy;
  logic [3:0]   wb_pos;
  logic [31:0]  wb_val;
  logic [31:0]  rd_ptr;
  logic [31:0]  rd_val;
  logic         rd_ok;
  logic [3:0]   dbusy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_reservation_station #(.OPCODE_LW(LW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .op                   (op),
    .pos                  (pos),
    .qi                   (qi),
    .vi                   (vi),
    .qj                   (qj),
    .vj                   (vj),
    .qk                   (qk),
    .vk                   (vk),
    .commonDataBus        (cdb),
    .busy                 (busy),
    .writeBuffer_position (wb_pos),
    .writeBuffer_value    (wb_val),
    .dCache_readPtr       (rd_ptr),
    .dCache_readValue     (rd_val),
    .dCache_readSuccess   (rd_ok),
    .dCache_busy          (dbusy)
  );

  task automatic check(input string name, input logic eb, input logic [31:0] ep,
                       input logic [3:0] ewp, input logic [31:0] ewv);
    n_tests++;
    if ({busy, rd_ptr, wb_pos, wb_val} !== {eb, ep, ewp, ewv}) begin
      n_fail++;
      $display("FAIL %s: got busy=%0b ptr=%h wbpos=%h wbval=%h, expected busy=%0b ptr=%h wbpos=%h wbval=%h",
               name, busy, rd_ptr, wb_pos, wb_val, eb, ep, ewp, ewv);
    end
  endtask

  task automatic idle_inputs();
    op = 4'h0; pos = 4'h0; qi = 4'h0; vi = 32'h0;
    qj = RDY; vj = 32'h0; qk = RDY; vk = 32'h0;
    cdb = {16{IDLE_SLOT}};
    rd_val = 32'h0; rd_ok = 1'b0; dbusy = 4'h0;
  endtask

  // ---------------- scripted cycle table ----------------
  typedef struct {
    logic [3:0]  op, pos, qj, qk;
    logic [31:0] vj, vk;
    int          sa;  logic [31:0] va;
    int          sb;  logic [31:0] vb;
    logic [3:0]  db;  logic succ; logic [31:0] rv;
    logic        e_busy; logic [31:0] e_ptr; logic [3:0] e_wbp; logic [31:0] e_wbv;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] o, input logic [3:0] p,
                              input logic [3:0] tj, input logic [31:0] xj,
                              input logic [3:0] tk, input logic [31:0] xk,
                              input int sa, input logic [31:0] va,
                              input int sb, input logic [31:0] vb,
                              input logic [3:0] db, input logic s, input logic [31:0] rv,
                              input logic eb, input logic [31:0] ep,
                              input logic [3:0] ewp, input logic [31:0] ewv);
    vec_t v;
    v.op = o; v.pos = p; v.qj = tj; v.vj = xj; v.qk = tk; v.vk = xk;
    v.sa = sa; v.va = va; v.sb = sb; v.vb = vb;
    v.db = db; v.succ = s; v.rv = rv;
    v.e_busy = eb; v.e_ptr = ep; v.e_wbp = ewp; v.e_wbv = ewv;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    idle_inputs();
    op = v.op; pos = v.pos; qj = v.qj; vj = v.vj; qk = v.qk; vk = v.vk;
    if (v.sa >= 0) cdb[v.sa*32 +: 32] = v.va;
    if (v.sb >= 0) cdb[v.sb*32 +: 32] = v.vb;
    dbusy = v.db; rd_ok = v.succ; rd_val = v.rv;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_reading;
  logic [3:0]  m_pos, m_wbp;
  logic [31:0] m_ptr, m_wbv;
  bit          m_have [2];
  logic [3:0]  m_tag  [2];
  logic [31:0] m_val  [2];

  function automatic void model_reset();
    m_busy = 0; m_reading = 0; m_pos = 0; m_wbp = 0; m_ptr = 0; m_wbv = 0;
    for (int i = 0; i < 2; i++) begin m_have[i] = 0; m_tag[i] = 0; m_val[i] = 0; end
  endfunction

  function automatic void model_resolve();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] slot;
      slot = cdb[int'(m_tag[i])*32 +: 32];
      if (!m_have[i] && slot != IDLE_SLOT) begin m_have[i] = 1; m_val[i] = slot; end
    end
    if (m_have[0] && m_have[1] && dbusy == 4'h0) begin
      m_reading = 1;
      m_ptr = m_val[0] + m_val[1];
    end
  endfunction

  // Advance the model by one rising edge using the inputs currently driven
  function automatic void model_edge();
    if (!m_busy) begin
      if (op == LW) begin
        m_busy = 1; m_pos = pos;
        m_tag[0] = qj; m_have[0] = (qj == RDY); m_val[0] = vj;
        m_tag[1] = qk; m_have[1] = (qk == RDY); m_val[1] = vk;
        model_resolve();
      end
    end else if (m_reading) begin
      if (rd_ok) begin
        m_wbv = rd_val; m_wbp = m_pos; m_busy = 0; m_reading = 0;
      end
    end else begin
      model_resolve();
    end
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Cycle script: {inputs} -> {busy, ptr, wbpos, wbval} after the edge
    vecs[0]  = mk(LW,   4'h0, 4'h0, 32'd123, RDY, 32'd7,      -1, 0, -1, 0,        4'h0, 0, 0,   1, 32'd0,   4'h0, 32'd0);
    vecs[1]  = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 0, 32'd5, -1, 0,     4'h0, 0, 0,   1, 32'd12,  4'h0, 32'd0);
    vecs[2]  = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 1, 32'd99, 0, 32'd12, 4'h0, 32'd99);
    vecs[3]  = mk(LW,   4'h3, RDY, 32'hFFFF_FFFF, RDY, 32'd2, -1, 0, -1, 0,        4'h0, 0, 0,   1, 32'd1,   4'h0, 32'd99);
    vecs[4]  = mk(LW,   4'h5, RDY, 32'd50, RDY, 32'd50,       -1, 0, -1, 0,        4'h0, 0, 0,   1, 32'd1,   4'h0, 32'd99);
    vecs[5]  = mk(LW,   4'h5, RDY, 32'd50, RDY, 32'd50,       -1, 0, -1, 0,        4'h0, 1, 32'hAAAA, 0, 32'd1, 4'h3, 32'hAAAA);
    vecs[6]  = mk(LW,   4'h6, RDY, 32'd100, RDY, 32'd4,       -1, 0, -1, 0,        4'h2, 0, 0,   1, 32'd1,   4'h3, 32'hAAAA);
    vecs[7]  = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h2, 0, 0,   1, 32'd1,   4'h3, 32'hAAAA);
    vecs[8]  = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h2, 1, 32'd77, 1, 32'd1, 4'h3, 32'hAAAA);
    vecs[9]  = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 0, 0,   1, 32'd104, 4'h3, 32'hAAAA);
    vecs[10] = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 1, 32'h55, 0, 32'd104, 4'h6, 32'h55);
    vecs[11] = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 1, 32'h66, 0, 32'd104, 4'h6, 32'h55);
    vecs[12] = mk(LW,   4'h9, 4'h2, 32'd1000, 4'h2, 32'd2000, 2, 32'h10, -1, 0,    4'h0, 0, 0,   1, 32'h20,  4'h6, 32'h55);
    vecs[13] = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 1, 32'd1, 0, 32'h20,  4'h9, 32'd1);
    vecs[14] = mk(LW,   4'hA, 4'h1, 32'd9, 4'h4, 32'd9,       -1, 0, -1, 0,        4'h0, 0, 0,   1, 32'h20,  4'h9, 32'd1);
    vecs[15] = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 1, 32'h100, 4, 32'h23, 4'h0, 0, 0, 1, 32'h123, 4'h9, 32'd1);
    vecs[16] = mk(4'h0, 4'h0, RDY, 0, RDY, 0,                 -1, 0, -1, 0,        4'h0, 1, 32'd7, 0, 32'h123, 4'hA, 32'd7);
    vecs[17] = mk(4'h3, 4'hB, RDY, 32'd1, RDY, 32'd1,         -1, 0, -1, 0,        4'h0, 0, 0,   0, 32'h123, 4'hA, 32'd7);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 1'b0, 32'd0, 4'h0, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_ptr, vecs[i].e_wbp, vecs[i].e_wbv);
    end

    // Async reset while in READ clears everything at once; later success ignored
    idle_inputs();
    op = LW; pos = 4'h2; vj = 32'h40; vk = 32'h4;
    @(posedge clk);
    #1;
    check("pre_reset_read", 1'b1, 32'h44, 4'hA, 32'd7);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_read", 1'b0, 32'd0, 4'h0, 32'd0);
    rd_ok = 1'b1; rd_val = 32'hDEAD;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("success_after_reset_1", 1'b0, 32'd0, 4'h0, 32'd0);
    @(posedge clk);
    #1;
    check("success_after_reset_2", 1'b0, 32'd0, 4'h0, 32'd0);

    // Randomized traffic against the model
    idle_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      op  = ($urandom_range(0, 1) == 0) ? LW : 4'($urandom_range(0, 15));
      pos = 4'($urandom_range(0, 15));
      qi  = 4'($urandom); vi = $urandom;
      qj  = ($urandom_range(0, 1) == 0) ? RDY : 4'($urandom_range(0, 15));
      qk  = ($urandom_range(0, 1) == 0) ? RDY : 4'($urandom_range(0, 15));
      vj  = $urandom; vk = $urandom;
      cdb = {16{IDLE_SLOT}};
      for (int s = 0; s < 16; s++)
        if ($urandom_range(0, 9) == 0) cdb[s*32 +: 32] = 32'($urandom_range(0, 32'h7FFF_FFFF));
      dbusy  = ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(1, 15));
      rd_ok  = 1'($urandom_range(0, 1));
      rd_val = $urandom;
      model_edge();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", c), m_busy, m_ptr, m_wbp, m_wbv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
